prog_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle core top level and its instruction memory. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written into instruction memory at consecutive word addresses. The core is held in reset until a complete, checksum-verified image has been written, replacing simulation-only memory preloading with a synthesizable load path.

---
 rtl/loader_pkg.sv | 18 +
 rtl/word_assembler.sv | 35 +++
 rtl/prog_loader.sv | 117 +++++++++++
 tb/tb_prog_loader.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and sizing for the boot-time program loader.
package loader_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;
  localparam int LEN_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted bytes little-endian into 32-bit words and keeps a running XOR checksum.
// word_ready is combinational on the 4th byte; word holds the full word the following cycle. Never stalls.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_dat,
  output logic [31:0] word,
  output logic [7:0]  csum,
  output logic        word_ready
);

  logic [1:0] byte_cnt;

  assign word_ready = byte_en && (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word     <= '0;
      csum     <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      word     <= '0;
      csum     <= '0;
      byte_cnt <= '0;
    end else if (byte_en) begin
      // Shift right so the first byte of a word ends up in bits [7:0].
      word     <= {byte_dat, word[31:8]};
      csum     <= csum ^ byte_dat;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Receives a length/data/checksum byte frame and writes the image into instruction memory, holding the core in reset until verified.
// Memory write lands 1 cycle after a word's 4th byte; BYTE_READY is high in every receiving state and never stalls.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [7:0]        BYTE_IN,
  input  logic              BYTE_VALID,
  output logic              BYTE_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  output logic              CORE_RESET_N,
  output logic              DONE,
  output logic              ERROR
);

  state_t            state;
  logic [LEN_W-1:0]  n_len;
  logic [LEN_W-1:0]  widx;
  logic [LEN_W-1:0]  len_full;
  logic [7:0]        csum;
  logic              accept;
  logic              data_en;
  logic              word_done;
  logic              len_bad;

  assign BYTE_READY = ((state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA)   || (state == S_CHECK)) && !START;
  assign accept     = BYTE_VALID && BYTE_READY;
  assign data_en    = accept && (state == S_DATA);
  assign len_full   = {BYTE_IN, n_len[7:0]};
  assign len_bad    = (len_full == '0) || (int'(len_full) > DEPTH);

  word_assembler u_asm (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .clear      (START),
    .byte_en    (data_en),
    .byte_dat   (BYTE_IN),
    .word       (MEM_WDATA),
    .csum       (csum),
    .word_ready (word_done)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= S_IDLE;
      n_len        <= '0;
      widx         <= '0;
      MEM_WE       <= 1'b0;
      MEM_ADDR     <= '0;
      CORE_RESET_N <= 1'b0;
      DONE         <= 1'b0;
      ERROR        <= 1'b0;
    end else if (START) begin
      state        <= S_LEN_LO;
      n_len        <= '0;
      widx         <= '0;
      MEM_WE       <= 1'b0;
      MEM_ADDR     <= '0;
      CORE_RESET_N <= 1'b0;
      DONE         <= 1'b0;
      ERROR        <= 1'b0;
    end else begin
      MEM_WE <= word_done;
      case (state)
        S_LEN_LO: begin
          if (accept) begin
            n_len[7:0] <= BYTE_IN;
            state      <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            n_len[15:8] <= BYTE_IN;
            if (len_bad) begin
              state <= S_ERR;
              ERROR <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // Address is captured with the strobe so it is stable during the write cycle.
          if (word_done) begin
            MEM_ADDR <= widx[ADDR_W-1:0];
            widx     <= widx + LEN_W'(1);
            if (widx == n_len - LEN_W'(1)) begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (accept) begin
            if (BYTE_IN == csum) begin
              state        <= S_DONE;
              DONE         <= 1'b1;
              CORE_RESET_N <= 1'b1;
            end else begin
              state <= S_ERR;
              ERROR <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a frame-level reference model.
module tb_prog_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              START = 1'b0;
  logic [7:0]        BYTE_IN = '0;
  logic              BYTE_VALID = 1'b0;
  logic              BYTE_READY;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [31:0]       MEM_WDATA;
  logic              CORE_RESET_N;
  logic              DONE;
  logic              ERROR;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .START        (START),
    .BYTE_IN      (BYTE_IN),
    .BYTE_VALID   (BYTE_VALID),
    .BYTE_READY   (BYTE_READY),
    .MEM_WE       (MEM_WE),
    .MEM_ADDR     (MEM_ADDR),
    .MEM_WDATA    (MEM_WDATA),
    .CORE_RESET_N (CORE_RESET_N),
    .DONE         (DONE),
    .ERROR        (ERROR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: words of the image, the serialized frame, and expected write cycles.
  logic [31:0]       words[$];
  logic [7:0]        frame_q[$];
  int                exp_cyc_q[$];
  int                last_acc;

  logic [ADDR_W-1:0] act_addr_q[$];
  logic [31:0]       act_data_q[$];
  int                act_cyc_q[$];

  always @(negedge CLK) begin
    if (MEM_WE === 1'b1) begin
      act_addr_q.push_back(MEM_ADDR);
      act_data_q.push_back(MEM_WDATA);
      act_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_obs();
    act_addr_q.delete();
    act_data_q.delete();
    act_cyc_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic build_frame(input bit bad_check);
    logic [15:0] n;
    logic [31:0] w;
    logic [7:0]  x;
    n = 16'(words.size());
    x = 8'h00;
    frame_q.delete();
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    foreach (words[i]) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        frame_q.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    frame_q.push_back(bad_check ? ~x : x);
  endtask

  // Entered and left at posedge+1; returns once the byte has been accepted.
  task automatic push_byte(input logic [7:0] b, input int gap_max);
    int g;
    int t;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    BYTE_VALID = 1'b0;
    repeat (g) begin
      @(posedge CLK);
      #1;
    end
    BYTE_VALID = 1'b1;
    BYTE_IN    = b;
    t = 0;
    forever begin
      @(negedge CLK);
      if (BYTE_READY === 1'b1) break;
      t++;
      if (t > 50) begin
        n_cmp++;
        n_fail++;
        $display("FAIL byte_accept_timeout ready=%b want 1", BYTE_READY);
        break;
      end
      @(posedge CLK);
      #1;
    end
    @(posedge CLK);
    #1;
    last_acc   = cyc;
    BYTE_VALID = 1'b0;
  endtask

  task automatic run_frame(input int first, input int last, input int gap_max);
    for (int i = first; i < last; i++) begin
      push_byte(frame_q[i], gap_max);
      if (i >= 2 && i < 2 + 4 * words.size() && ((i - 2) % 4) == 3)
        exp_cyc_q.push_back(last_acc);
    end
  endtask

  task automatic do_start();
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    clear_obs();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if ({MEM_WE, MEM_ADDR, MEM_WDATA, CORE_RESET_N, DONE, ERROR, BYTE_READY} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs we=%b addr=%0d wdata=%h crn=%b done=%b err=%b rdy=%b want all 0",
               MEM_WE, MEM_ADDR, MEM_WDATA, CORE_RESET_N, DONE, ERROR, BYTE_READY);
    end
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    BYTE_VALID = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (BYTE_READY !== 1'b0 || act_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_ready rdy=%b writes=%0d want 0/0", BYTE_READY, act_addr_q.size());
    end
    @(posedge CLK);
    #1;
    BYTE_VALID = 1'b0;
  endtask

  task automatic test_single();
    words.delete();
    words.push_back(32'h00A00513);
    build_frame(1'b0);
    n_cmp++;
    if (frame_q[6] !== 8'hB6) begin
      n_fail++;
      $display("FAIL single_model_check got %h want b6", frame_q[6]);
    end
    do_start();
    run_frame(0, frame_q.size(), 0);
    @(negedge CLK);
    n_cmp++;
    if (DONE !== 1'b1 || CORE_RESET_N !== 1'b1 || ERROR !== 1'b0) begin
      n_fail++;
      $display("FAIL single_status done=%b crn=%b err=%b want 1/1/0", DONE, CORE_RESET_N, ERROR);
    end
    n_cmp++;
    if (act_addr_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_count got %0d want 1", act_addr_q.size());
    end else if (act_addr_q[0] !== '0 || act_data_q[0] !== 32'h00A00513 || act_cyc_q[0] !== exp_cyc_q[0]) begin
      n_fail++;
      $display("FAIL single_write got a=%0d d=%h c=%0d want a=0 d=00a00513 c=%0d",
               act_addr_q[0], act_data_q[0], act_cyc_q[0], exp_cyc_q[0]);
    end
    // Status holds and no bytes are taken once the image is verified.
    @(posedge CLK);
    #1;
    BYTE_VALID = 1'b1;
    BYTE_IN    = 8'($urandom);
    repeat (5) @(posedge CLK);
    #1;
    BYTE_VALID = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (DONE !== 1'b1 || CORE_RESET_N !== 1'b1 || BYTE_READY !== 1'b0 || act_addr_q.size() != 1) begin
      n_fail++;
      $display("FAIL done_hold done=%b crn=%b rdy=%b writes=%0d want 1/1/0/1",
               DONE, CORE_RESET_N, BYTE_READY, act_addr_q.size());
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_back_to_back();
    rand_words(3);
    build_frame(1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      do_start();
      run_frame(0, frame_q.size(), (pass == 0) ? 0 : 3);
      @(negedge CLK);
      n_cmp++;
      if (DONE !== 1'b1 || ERROR !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_status pass=%0d done=%b err=%b want 1/0", pass, DONE, ERROR);
      end
      n_cmp++;
      if (act_addr_q.size() != 3) begin
        n_fail++;
        $display("FAIL b2b_count pass=%0d got %0d want 3", pass, act_addr_q.size());
      end
      for (int i = 0; i < act_addr_q.size() && i < 3; i++) begin
        n_cmp++;
        if (act_addr_q[i] !== ADDR_W'(i) || act_data_q[i] !== words[i] || act_cyc_q[i] !== exp_cyc_q[i]) begin
          n_fail++;
          $display("FAIL b2b_write pass=%0d [%0d] got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                   pass, i, act_addr_q[i], act_data_q[i], act_cyc_q[i], i, words[i], exp_cyc_q[i]);
        end
        if (pass == 0 && i > 0) begin
          n_cmp++;
          if (act_cyc_q[i] - act_cyc_q[i-1] != 4) begin
            n_fail++;
            $display("FAIL b2b_spacing [%0d] got %0d want 4", i, act_cyc_q[i] - act_cyc_q[i-1]);
          end
        end
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_bad_len();
    logic [15:0] lens[3];
    lens[0] = 16'h0000;
    lens[1] = 16'h0401;
    lens[2] = 16'($urandom_range(65535, DEPTH + 1));
    for (int k = 0; k < 3; k++) begin
      do_start();
      push_byte(lens[k][7:0], 2);
      push_byte(lens[k][15:8], 2);
      BYTE_VALID = 1'b1;
      BYTE_IN    = 8'($urandom);
      @(negedge CLK);
      n_cmp++;
      if (ERROR !== 1'b1 || DONE !== 1'b0 || BYTE_READY !== 1'b0 || CORE_RESET_N !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_len_status len=%h err=%b done=%b rdy=%b crn=%b want 1/0/0/0",
                 lens[k], ERROR, DONE, BYTE_READY, CORE_RESET_N);
      end
      repeat (6) @(posedge CLK);
      #1;
      BYTE_VALID = 1'b0;
      n_cmp++;
      if (act_addr_q.size() != 0 || ERROR !== 1'b1) begin
        n_fail++;
        $display("FAIL bad_len_writes len=%h writes=%0d err=%b want 0/1", lens[k], act_addr_q.size(), ERROR);
      end
    end
  endtask

  task automatic test_bad_check();
    words.delete();
    words.push_back(32'h00A00513);
    build_frame(1'b0);
    frame_q[6] = 8'h00;
    do_start();
    run_frame(0, frame_q.size(), 2);
    @(negedge CLK);
    n_cmp++;
    if (ERROR !== 1'b1 || DONE !== 1'b0 || CORE_RESET_N !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_check_status err=%b done=%b crn=%b want 1/0/0", ERROR, DONE, CORE_RESET_N);
    end
    n_cmp++;
    if (act_addr_q.size() != 1 || act_addr_q[0] !== '0 || act_data_q[0] !== 32'h00A00513) begin
      n_fail++;
      $display("FAIL bad_check_write writes=%0d want 1 at addr 0 data 00a00513", act_addr_q.size());
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_restart();
    rand_words(2);
    build_frame(1'b0);
    do_start();
    run_frame(0, 8, 1);
    BYTE_VALID = 1'b1;
    BYTE_IN    = frame_q[8];
    START      = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (BYTE_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_ready got %b want 0", BYTE_READY);
    end
    @(posedge CLK);
    #1;
    START      = 1'b0;
    BYTE_VALID = 1'b0;
    clear_obs();
    @(negedge CLK);
    n_cmp++;
    if (BYTE_READY !== 1'b1 || MEM_ADDR !== '0 || DONE !== 1'b0 || ERROR !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_state rdy=%b addr=%0d done=%b err=%b want 1/0/0/0",
               BYTE_READY, MEM_ADDR, DONE, ERROR);
    end
    @(posedge CLK);
    #1;
    rand_words(2);
    build_frame(1'b0);
    run_frame(0, frame_q.size(), 2);
    @(negedge CLK);
    n_cmp++;
    if (DONE !== 1'b1 || act_addr_q.size() != 2) begin
      n_fail++;
      $display("FAIL restart_done done=%b writes=%0d want 1/2", DONE, act_addr_q.size());
    end
    for (int i = 0; i < act_addr_q.size() && i < 2; i++) begin
      n_cmp++;
      if (act_addr_q[i] !== ADDR_W'(i) || act_data_q[i] !== words[i] || act_cyc_q[i] !== exp_cyc_q[i]) begin
        n_fail++;
        $display("FAIL restart_write [%0d] got a=%0d d=%h want a=%0d d=%h",
                 i, act_addr_q[i], act_data_q[i], i, words[i]);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset_full_image();
    int bad;
    rand_words(4);
    build_frame(1'b0);
    do_start();
    run_frame(0, 9, 0);
    RESET_N = 1'b0;
    #2;
    n_cmp++;
    if ({MEM_WE, MEM_ADDR, MEM_WDATA, CORE_RESET_N, DONE, ERROR, BYTE_READY} !== '0) begin
      n_fail++;
      $display("FAIL midload_reset we=%b addr=%0d wdata=%h crn=%b done=%b err=%b rdy=%b want all 0",
               MEM_WE, MEM_ADDR, MEM_WDATA, CORE_RESET_N, DONE, ERROR, BYTE_READY);
    end
    clear_obs();
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    BYTE_VALID = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    BYTE_VALID = 1'b0;
    n_cmp++;
    if (act_addr_q.size() != 0 || DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle writes=%0d done=%b want 0/0", act_addr_q.size(), DONE);
    end
    rand_words(DEPTH);
    build_frame(1'b0);
    do_start();
    run_frame(0, frame_q.size(), 1);
    @(negedge CLK);
    n_cmp++;
    if (DONE !== 1'b1 || CORE_RESET_N !== 1'b1 || ERROR !== 1'b0 || act_addr_q.size() != DEPTH) begin
      n_fail++;
      $display("FAIL full_image_status done=%b crn=%b err=%b writes=%0d want 1/1/0/%0d",
               DONE, CORE_RESET_N, ERROR, act_addr_q.size(), DEPTH);
    end
    bad = 0;
    for (int i = 0; i < act_addr_q.size() && i < DEPTH; i++) begin
      if (act_addr_q[i] !== ADDR_W'(i) || act_data_q[i] !== words[i] || act_cyc_q[i] !== exp_cyc_q[i]) begin
        if (bad == 0)
          $display("FAIL full_image_write [%0d] got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                   i, act_addr_q[i], act_data_q[i], act_cyc_q[i], i, words[i], exp_cyc_q[i]);
        bad++;
      end
    end
    n_cmp++;
    if (bad != 0) n_fail++;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout cycles=%0d want completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_len();
    test_bad_check();
    test_restart();
    test_reset_full_image();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
